// File: rtl/z80_bus_responder.sv
// z80_bus_responder: Z80 bus slave that maps CPU memory cycles to a synchronous RAM port and I/O cycles to an I/O port.
// Latency: the strobe is sampled, one ACCESS clk follows, then MEM_WAIT/IO_WAIT wait clks, then HOLD until the strobes release.
// Backpressure: stalls the CPU with wait_n, which is low only in WAIT; no new cycle starts until every strobe is high again.
//
// Optional feature: define Z80_IACK_VEC_EN to answer interrupt-acknowledge cycles (M1+IORQ) with IACK_VECTOR.
// Ports:
//   clk, reset                     sole clock; asynchronous active-high reset
//   m1_n mreq_n iorq_n rd_n wr_n rfsh_n, A[15:0], dout[7:0]   CPU bus inputs
//   di[7:0], wait_n                data to the CPU, WAIT request (active low)
//   mem_addr mem_en mem_we mem_wdata / mem_rdata   synchronous RAM, read data one clk after mem_en
//   io_addr io_rd io_wr io_wdata / io_rdata        I/O port, io_rdata combinational
//   proto_err                      sticky bus-protocol error, cleared only by reset
module z80_bus_responder #(
    parameter int         MEM_WAIT    = 0,
    parameter int         IO_WAIT     = 1,
    parameter logic [7:0] IACK_VECTOR = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  dout,
    output logic [7:0]  di,
    output logic        wait_n,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  io_addr,
    output logic        io_rd,
    output logic        io_wr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, HOLD} state_t;

    localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);
    localparam logic [3:0] IO_WAIT_C  = 4'(IO_WAIT);

    state_t      state_q, state_d;
    logic        cyc_io_q, cyc_iack_q, cyc_wr_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [3:0]  wait_cnt_q;
    logic        rd_pend_q;
    logic [7:0]  di_q;
    logic        proto_err_q;

    logic       mem_start, io_start, iack_start, any_start;
    logic       dir_wr, rd_wr_clash, bus_idle, cyc_gone;
    logic [3:0] wait_sel;

    // Refresh is excluded by rfsh_n; memory wins when MREQ and IORQ collide.
    assign mem_start   = !mreq_n && rfsh_n && (!rd_n || !wr_n);
    assign io_start    = !iorq_n && m1_n && (!rd_n || !wr_n) && !mem_start;
`ifdef Z80_IACK_VEC_EN
    assign iack_start  = !iorq_n && !m1_n && !mem_start;
`else
    assign iack_start  = 1'b0;
`endif
    assign any_start   = mem_start || io_start || iack_start;
    assign rd_wr_clash = !rd_n && !wr_n;
    assign dir_wr      = !wr_n && rd_n;      // RD+WR together is treated as a read
    assign bus_idle    = rd_n && wr_n && mreq_n && iorq_n;

    // The CPU has abandoned the cycle when its request strobe or its
    // direction strobes (none for IACK) have gone away.
    assign cyc_gone = ((cyc_io_q || cyc_iack_q) ? iorq_n : mreq_n) ||
                      (!cyc_iack_q && rd_n && wr_n);
    assign wait_sel = (cyc_io_q || cyc_iack_q) ? IO_WAIT_C : MEM_WAIT_C;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_start) state_d = ACCESS;
            ACCESS:  state_d = (wait_sel != 4'd0) ? WAIT : HOLD;
            WAIT: begin
                if (cyc_gone)                state_d = IDLE;
                else if (wait_cnt_q <= 4'd1) state_d = HOLD;
            end
            HOLD:    if (bus_idle) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Cycle context, wait counter, read data and error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_io_q    <= 1'b0;
            cyc_iack_q  <= 1'b0;
            cyc_wr_q    <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            wait_cnt_q  <= 4'd0;
            rd_pend_q   <= 1'b0;
            di_q        <= 8'h00;
            proto_err_q <= 1'b0;
        end else begin
            if (state_q == IDLE && any_start) begin
                addr_q     <= A;
                wdata_q    <= dout;
                cyc_io_q   <= io_start;
                cyc_iack_q <= iack_start;
                cyc_wr_q   <= dir_wr && !iack_start;
            end

            // Loaded while leaving ACCESS; counts down to zero and stops there.
            if (state_q == ACCESS)
                wait_cnt_q <= wait_sel;
            else if (state_q == WAIT && cyc_gone)
                wait_cnt_q <= 4'd0;
            else if (state_q == WAIT && wait_cnt_q != 4'd0)
                wait_cnt_q <= wait_cnt_q - 4'd1;

            // RAM data appears one clk after mem_en, so memory reads land a cycle late.
            rd_pend_q <= (state_q == ACCESS) && !cyc_io_q && !cyc_iack_q && !cyc_wr_q;
            if (rd_pend_q)
                di_q <= mem_rdata;
            else if (state_q == ACCESS && cyc_iack_q)
                di_q <= IACK_VECTOR;
            else if (state_q == ACCESS && cyc_io_q && !cyc_wr_q)
                di_q <= io_rdata;

            if (state_q == IDLE && ((!mreq_n && !iorq_n) || (any_start && rd_wr_clash)))
                proto_err_q <= 1'b1;
            if (state_q == WAIT && cyc_gone)
                proto_err_q <= 1'b1;
        end
    end

    // Outputs decoded from state
    always_comb begin
        mem_en = 1'b0;
        mem_we = 1'b0;
        io_rd  = 1'b0;
        io_wr  = 1'b0;
        wait_n = 1'b1;
        case (state_q)
            ACCESS: begin
                if (!cyc_io_q && !cyc_iack_q) begin
                    mem_en = 1'b1;
                    mem_we = cyc_wr_q;
                end else if (cyc_io_q) begin
                    io_rd = !cyc_wr_q;
                    io_wr = cyc_wr_q;
                end
            end
            WAIT:    wait_n = 1'b0;
            default: ;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign io_addr   = addr_q[7:0];
    assign io_wdata  = wdata_q;
    assign di        = di_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder: drives one Z80 bus into three responders with different wait settings.
// Inst 0: MEM_WAIT=0 IO_WAIT=1; inst 1: MEM_WAIT=3 IO_WAIT=2; inst 2: MEM_WAIT=5 IO_WAIT=0.
// Each instance has its own RAM model and a combinational I/O model (port 5A -> 3C, others -> 11).
module tb_z80_bus_responder;

    localparam int N = 3;

    localparam int OP_FETCH = 0;
    localparam int OP_RD    = 1;
    localparam int OP_WR    = 2;
    localparam int OP_IN    = 3;
    localparam int OP_OUT   = 4;
    localparam int OP_RFSH  = 5;
    localparam int OP_IACK  = 6;
    localparam int OP_RDWR  = 7;
    localparam int OP_MIO   = 8;

`ifdef Z80_IACK_VEC_EN
    localparam bit IACK_ON = 1'b1;
`else
    localparam bit IACK_ON = 1'b0;
`endif

    function automatic int mw(input int g);
        case (g)
            0:       return 0;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int iw(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            default: return 0;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
    logic [15:0] A;
    logic [7:0]  dout;

    logic [7:0]   di_v        [N];
    logic [N-1:0] wait_n_v, mem_en_v, mem_we_v, io_rd_v, io_wr_v, proto_err_v;
    logic [15:0]  mem_addr_v  [N];
    logic [7:0]   mem_wdata_v [N];
    logic [7:0]   io_addr_v   [N];
    logic [7:0]   io_wdata_v  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        logic [7:0] ram [65536];
        logic [7:0] mem_rdata;
        logic [7:0] io_rdata;

        assign io_rdata = (io_addr_v[g] == 8'h5A) ? 8'h3C : 8'h11;

        initial begin
            for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
            ram[16'h0000] = 8'hCB;
            ram[16'h0001] = 8'hC8;
            ram[16'h1234] = 8'hAA;
        end

        always @(posedge clk) begin
            if (mem_en_v[g]) begin
                mem_rdata = ram[mem_addr_v[g]];
                if (mem_we_v[g]) ram[mem_addr_v[g]] = mem_wdata_v[g];
            end
        end

        z80_bus_responder #(
            .MEM_WAIT   (mw(g)),
            .IO_WAIT    (iw(g)),
            .IACK_VECTOR(8'hFF)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .m1_n     (m1_n),
            .mreq_n   (mreq_n),
            .iorq_n   (iorq_n),
            .rd_n     (rd_n),
            .wr_n     (wr_n),
            .rfsh_n   (rfsh_n),
            .A        (A),
            .dout     (dout),
            .di       (di_v[g]),
            .wait_n   (wait_n_v[g]),
            .mem_addr (mem_addr_v[g]),
            .mem_en   (mem_en_v[g]),
            .mem_we   (mem_we_v[g]),
            .mem_wdata(mem_wdata_v[g]),
            .mem_rdata(mem_rdata),
            .io_addr  (io_addr_v[g]),
            .io_rd    (io_rd_v[g]),
            .io_wr    (io_wr_v[g]),
            .io_wdata (io_wdata_v[g]),
            .io_rdata (io_rdata),
            .proto_err(proto_err_v[g])
        );
    end

    // Strobe activity counters and captured write/port values, sampled mid-cycle.
    int         wl  [N] = '{default: 0};
    int         men [N] = '{default: 0};
    int         mwe [N] = '{default: 0};
    int         ior [N] = '{default: 0};
    int         iow [N] = '{default: 0};
    logic [15:0] cap_maddr [N];
    logic [7:0]  cap_mwd   [N];
    logic [7:0]  cap_ioa   [N];
    logic [7:0]  cap_iowd  [N];

    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (!wait_n_v[g]) wl[g]++;
            if (mem_en_v[g]) begin
                men[g]++;
                if (mem_we_v[g]) begin
                    mwe[g]++;
                    cap_maddr[g] = mem_addr_v[g];
                    cap_mwd[g]   = mem_wdata_v[g];
                end
            end
            if (io_rd_v[g]) begin
                ior[g]++;
                cap_ioa[g] = io_addr_v[g];
            end
            if (io_wr_v[g]) begin
                iow[g]++;
                cap_ioa[g]  = io_addr_v[g];
                cap_iowd[g] = io_wdata_v[g];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int id, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s v%0d inst%0d: got %0h want %0h", name, id, g, act, exp);
        end
    endtask

    int s_wl [N], s_men [N], s_mwe [N], s_ior [N], s_iow [N];

    task automatic snap();
        s_wl  = wl;
        s_men = men;
        s_mwe = mwe;
        s_ior = ior;
        s_iow = iow;
    endtask

    task automatic release_bus();
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    // Called at posedge+1; holds the strobes long enough for the slowest instance.
    task automatic bus_op(input int op, input logic [15:0] addr, input logic [7:0] wd);
        A    = addr;
        dout = wd;
        case (op)
            OP_FETCH: begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
            OP_RD:    begin mreq_n = 1'b0; rd_n = 1'b0; end
            OP_WR:    begin mreq_n = 1'b0; wr_n = 1'b0; end
            OP_IN:    begin iorq_n = 1'b0; rd_n = 1'b0; end
            OP_OUT:   begin iorq_n = 1'b0; wr_n = 1'b0; end
            OP_RFSH:  begin mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0; end
            OP_IACK:  begin m1_n = 1'b0; iorq_n = 1'b0; end
            OP_RDWR:  begin mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; end
            OP_MIO:   begin mreq_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0; end
            default:  ;
        endcase
        repeat (10) @(posedge clk);
        #1 release_bus();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_counts(input int id, input int g, input int ew, input int emen,
                              input int emwe, input int eior, input int eiow);
        chk("wait_low_clks", id, g, wl[g]  - s_wl[g],  ew);
        chk("mem_en_pulses", id, g, men[g] - s_men[g], emen);
        chk("mem_we_pulses", id, g, mwe[g] - s_mwe[g], emwe);
        chk("io_rd_pulses",  id, g, ior[g] - s_ior[g], eior);
        chk("io_wr_pulses",  id, g, iow[g] - s_iow[g], eiow);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  exp_di;
    } vec_t;

    task automatic run_vec(input vec_t v, input int id);
        int ew, emen, eior, eiow, emwe;
        snap();
        bus_op(v.op, v.addr, v.wd);
        for (int g = 0; g < N; g++) begin
            emen = (v.op == OP_FETCH || v.op == OP_RD || v.op == OP_WR) ? 1 : 0;
            emwe = (v.op == OP_WR)  ? 1 : 0;
            eior = (v.op == OP_IN)  ? 1 : 0;
            eiow = (v.op == OP_OUT) ? 1 : 0;
            if (emen == 1)                          ew = mw(g);
            else if (eior == 1 || eiow == 1)        ew = iw(g);
            else if (v.op == OP_IACK && IACK_ON)    ew = iw(g);
            else                                    ew = 0;
            chk("di", id, g, di_v[g], v.exp_di);
            chk_counts(id, g, ew, emen, emwe, eior, eiow);
            chk("proto_err", id, g, proto_err_v[g], 0);
            if (v.op == OP_WR) begin
                chk("mem_addr", id, g, cap_maddr[g], v.addr);
                chk("mem_wdata", id, g, cap_mwd[g], v.wd);
            end
            if (v.op == OP_IN || v.op == OP_OUT) chk("io_addr", id, g, cap_ioa[g], v.addr[7:0]);
            if (v.op == OP_OUT) chk("io_wdata", id, g, cap_iowd[g], v.wd);
        end
    endtask

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{OP_FETCH, 16'h0000, 8'h00, 8'hCB};
        vecs[1] = '{OP_FETCH, 16'h0001, 8'h00, 8'hC8};
        vecs[2] = '{OP_WR,    16'h7CF3, 8'h75, 8'hC8};
        vecs[3] = '{OP_RD,    16'h7CF3, 8'h00, 8'h75};
        vecs[4] = '{OP_RD,    16'h1234, 8'h00, 8'hAA};
        vecs[5] = '{OP_IN,    16'h005A, 8'h00, 8'h3C};
        vecs[6] = '{OP_OUT,   16'h0033, 8'h5C, 8'h3C};
        vecs[7] = '{OP_RFSH,  16'h0042, 8'h00, 8'h3C};
        vecs[8] = '{OP_IACK,  16'h0000, 8'h00, IACK_ON ? 8'hFF : 8'h3C};
        vecs[9] = '{OP_IN,    16'h0077, 8'h00, 8'h11};

        reset = 1'b1;
        A = 16'h0000;
        dout = 8'h00;
        release_bus();
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            chk("rst_di", 0, g, di_v[g], 8'h00);
            chk("rst_wait_n", 0, g, wait_n_v[g], 1);
            chk("rst_strobes", 0, g, {mem_en_v[g], mem_we_v[g], io_rd_v[g], io_wr_v[g]}, 0);
            chk("rst_proto_err", 0, g, proto_err_v[g], 0);
            chk("rst_addr_data", 0, g,
                {mem_addr_v[g], mem_wdata_v[g], io_addr_v[g]} | {24'h0, io_wdata_v[g]}, 0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset asserted while the slow instance is mid-WAIT.
        A = 16'h1234; mreq_n = 1'b0; rd_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midwait_wait_n_before", 20, 2, wait_n_v[2], 0);
        reset = 1'b1;
        #1;
        for (int g = 0; g < N; g++) begin
            chk("midwait_wait_n_in_reset", 20, g, wait_n_v[g], 1);
            chk("midwait_di_in_reset", 20, g, di_v[g], 8'h00);
        end
        release_bus();
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        run_vec('{OP_RD, 16'h1234, 8'h00, 8'hAA}, 21);

        // Strobes withdrawn while waiting: abort with error where a WAIT was in progress.
        A = 16'h1234; mreq_n = 1'b0; rd_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++)
            chk("abort_wait_n_before", 22, g, wait_n_v[g], (mw(g) > 0) ? 0 : 1);
        release_bus();
        @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            chk("abort_proto_err", 22, g, proto_err_v[g], (mw(g) > 0) ? 1 : 0);
            chk("abort_wait_n_after", 22, g, wait_n_v[g], 1);
        end
        repeat (3) @(posedge clk);
        #1;

        // RD and WR together: served as a read, flagged.
        pulse_reset();
        snap();
        bus_op(OP_RDWR, 16'h1234, 8'h99);
        for (int g = 0; g < N; g++) begin
            chk("rdwr_di", 23, g, di_v[g], 8'hAA);
            chk_counts(23, g, mw(g), 1, 0, 0, 0);
            chk("rdwr_proto_err", 23, g, proto_err_v[g], 1);
        end

        // MREQ and IORQ together: memory wins, flag is sticky until reset.
        pulse_reset();
        for (int g = 0; g < N; g++) chk("reset_clears_err", 24, g, proto_err_v[g], 0);
        snap();
        bus_op(OP_MIO, 16'h1234, 8'h00);
        repeat (6) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            chk("mio_di", 25, g, di_v[g], 8'hAA);
            chk_counts(25, g, mw(g), 1, 0, 0, 0);
            chk("mio_proto_err_sticky", 25, g, proto_err_v[g], 1);
        end
        pulse_reset();
        for (int g = 0; g < N; g++) chk("final_reset_err", 26, g, proto_err_v[g], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/z80_bus_responder.md
Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0: wait states inserted on memory read/write (0-15).
REQ-002 SHALL have parameter IO_WAIT, default 1: wait states inserted on I/O read/write (0-15).
REQ-003 SHALL have parameter IACK_VECTOR, default 8'hFF: byte returned on interrupt acknowledge.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  Z80 bus strobes from CPU
- A  in  16  CPU address
- dout  in  8  CPU write data
- di  out  8  data to CPU
- wait_n  out  1  Z80 WAIT, active low
- mem_addr  out  16, mem_en  out  1, mem_we  out  1, mem_wdata  out  8, mem_rdata  in  8  synchronous RAM port; read data valid one clk after mem_en
- io_addr  out  8, io_rd  out  1, io_wr  out  1, io_wdata  out  8, io_rdata  in  8  I/O port; io_rdata combinational
- proto_err  out  1  sticky bus-protocol error

Function
REQ-005 SHALL use FSM states IDLE, ACCESS, WAIT, HOLD.
REQ-006 In IDLE, at a rising edge where mreq_n=0, rfsh_n=1, and (rd_n=0 or wr_n=0), SHALL start a memory cycle: latch A, dout, and direction, then go to ACCESS.
REQ-007 In IDLE, at a rising edge where iorq_n=0, m1_n=1, and (rd_n=0 or wr_n=0), SHALL start an I/O cycle on A[7:0] and go to ACCESS.
REQ-008 Refresh (mreq_n=0, rfsh_n=0) SHALL NOT start a cycle; mem_en, wait_n, and di are unaffected.
REQ-009 ACCESS SHALL last one clk, with mem_en (plus mem_we for writes) or io_rd/io_wr high for exactly that clk; mem_wdata/io_wdata SHALL equal the latched dout.
REQ-010 On the edge leaving ACCESS, SHALL go to WAIT if the wait count (MEM_WAIT or IO_WAIT) is >0, else HOLD.
REQ-011 wait_n SHALL be low for exactly the applicable wait count of clk cycles, starting the cycle after cycle start; it SHALL be high at all other times.
REQ-012 Read data: di SHALL be loaded from mem_rdata on the edge after ACCESS, or from io_rdata at the end of ACCESS.
REQ-013 di SHALL hold its value until the next read or IACK loads it.
REQ-014 HOLD SHALL remain until rd_n, wr_n, mreq_n, and iorq_n are all high, then go to IDLE; a new cycle SHALL NOT start before IDLE is reached.
REQ-015 If strobes deassert during WAIT, SHALL abort to IDLE, set proto_err, and release wait_n the next cycle.
REQ-016 mreq_n=0 and iorq_n=0 sampled together in IDLE SHALL set proto_err; memory SHALL take precedence.
REQ-017 rd_n=0 and wr_n=0 together SHALL set proto_err; the cycle SHALL be treated as a read.
REQ-018 Wait counter SHALL be 4 bits and SHALL count down without wrap.

Reset
REQ-019 Reset SHALL force IDLE asynchronously and clear the wait counter, including mid-WAIT.
REQ-020 Reset values: di=8'h00, wait_n=1, mem_en=0, mem_we=0, io_rd=0, io_wr=0, proto_err=0, address/data outputs=0.
REQ-021 After reset release, the first cycle start SHALL be recognised no earlier than the first rising edge after deassertion.

Configuration
REQ-022 With Z80_IACK_VEC_EN defined: m1_n=0 and iorq_n=0 in IDLE SHALL start an IACK cycle with no io_rd/mem_en, di=IACK_VECTOR, IO_WAIT waits, then HOLD.
REQ-023 Without Z80_IACK_VEC_EN: IACK cycles SHALL be ignored, with no strobes, di unchanged, wait_n high, and proto_err unaffected.

Verification
REQ-024 Opcode fetch: MEM_WAIT=0, RAM[0000]=CB, RAM[0001]=C8, CPU fetches 0000 then 0001 -> di=CB then C8; wait_n never low.
REQ-025 Write: MEM_WAIT=0, write 75 to 7CF3 -> one mem_en/mem_we pulse with mem_addr=7CF3 and mem_wdata=75; RAM[7CF3]=75.
REQ-026 Waits: MEM_WAIT=3, read 1234 holding AA -> wait_n low exactly 3 clk, di=AA; IO_WAIT=2, IN from port 5A returning 3C -> wait_n low 2 clk, di=3C, one io_rd pulse.
REQ-027 Refresh: mreq_n=0, rfsh_n=0, A=0042 -> no mem_en, di unchanged.
REQ-027a Mid-wait reset: assert reset mid-WAIT with MEM_WAIT=5 -> wait_n=1 immediately; IDLE; next read served normally.
REQ-028 IACK: M1+IORQ with macro defined -> di=FF, no io_rd; without macro -> di unchanged.
REQ-028a Protocol errors: mreq_n and iorq_n both low -> proto_err=1 and stays 1 until reset.
